stopwatch_ctrl: RTL and testbench

Stopwatch control block for the seven-segment display path. It consumes the single-cycle 1 Hz enable pulse and debounced, single-cycle button pulses, and runs a start/stop/lap/reset state machine. It maintains an MM:SS BCD count and drives four BCD digits, live or lap-frozen, to the seven-segment encoder/scanner downstream.

---
 rtl/stopwatch_pkg.sv | 20 ++
 rtl/stopwatch_ctrl_if.sv | 38 +++
 rtl/bcd_digit_counter.sv | 31 +++
 rtl/stopwatch_ctrl.sv | 129 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the stopwatch control block.
//   state_t      : control state (IDLE, RUN, PAUSE, LAP)
//   BCD_W        : width of one BCD digit
//   SEC_TENS_MAX : highest value of the seconds-tens digit
//   DIGIT_MAX    : highest value of any decimal digit
package stopwatch_pkg;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_MAX = 5;
    localparam int DIGIT_MAX    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if
// Bundles the stopwatch event inputs and display/status outputs.
//   tick, start_stop, lap_reset : one-cycle event pulses into the controller
//   min_tens, min_ones, sec_tens, sec_ones : displayed BCD digits
//   running, lap_active, wrap   : status outputs
//   state                       : current control state, for observation
// Handshake: there is no valid/ready pair. Every input is a one-cycle
// pulse acted on at the clock edge where it is sampled high; each high
// cycle is a separate event. Outputs are valid every cycle out of reset.
// modport master drives the events, modport slave is the controller.
interface stopwatch_ctrl_if;
    import stopwatch_pkg::*;

    logic               tick;
    logic               start_stop;
    logic               lap_reset;
    logic [BCD_W-1:0]   min_tens;
    logic [BCD_W-1:0]   min_ones;
    logic [BCD_W-1:0]   sec_tens;
    logic [BCD_W-1:0]   sec_ones;
    logic               running;
    logic               lap_active;
    logic               wrap;
    state_t             state;

    modport master (
        output tick, start_stop, lap_reset,
        input  min_tens, min_ones, sec_tens, sec_ones,
        input  running, lap_active, wrap, state
    );

    modport slave (
        input  tick, start_stop, lap_reset,
        output min_tens, min_ones, sec_tens, sec_ones,
        output running, lap_active, wrap, state
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter
// One BCD digit counting 0..MAX and wrapping to 0.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the digit this cycle
//   clr        : synchronous clear to 0 (wins over en)
//   value      : current digit
//   carry      : combinational, high when en and the digit is at MAX
module bcd_digit_counter #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    assign carry = en && (value == 4'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 4'd0;
        end else if (clr || carry) begin
            value <= 4'd0;
        end else if (en) begin
            value <= value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Start/stop/lap/reset stopwatch with an MM:SS BCD count and a lap register.
//   MAX_MINUTES : highest minute value before the count rolls to 00:00 (1..99)
//   clk, rst_n  : clock, asynchronous active-low reset
//   sw          : stopwatch_ctrl_if.slave (event inputs, digits, status)
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX_MINUTES = 59
) (
    input  logic              clk,
    input  logic              rst_n,
    stopwatch_ctrl_if.slave   sw
);

    localparam logic [3:0] MAX_MIN_TENS = 4'(MAX_MINUTES / 10);
    localparam logic [3:0] MAX_MIN_ONES = 4'(MAX_MINUTES % 10);
    localparam logic [3:0] D_MAX        = 4'(DIGIT_MAX);

    state_t     state, state_next;
    logic       inc, clr_count, lap_capture;
    logic       carry_ones, carry_tens;
    logic [3:0] sec_ones, sec_tens, min_tens, min_ones;
    logic [3:0] sec_ones_next, sec_tens_next, min_tens_next, min_ones_next;
    logic [3:0] lap_min_tens, lap_min_ones, lap_sec_tens, lap_sec_ones;
    logic       min_at_max, wrap;

    // start_stop wins over lap_reset in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sw.start_stop) state_next = RUN;
            RUN:     if (sw.start_stop) state_next = PAUSE;
                     else if (sw.lap_reset) state_next = LAP;
            LAP:     if (sw.start_stop) state_next = PAUSE;
                     else if (sw.lap_reset) state_next = RUN;
            PAUSE:   if (sw.start_stop) state_next = RUN;
                     else if (sw.lap_reset) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counting depends only on the state before the edge.
    assign inc         = sw.tick && (state == RUN || state == LAP);
    assign clr_count   = (state == PAUSE) && sw.lap_reset && !sw.start_stop;
    assign lap_capture = (state == RUN) && sw.lap_reset && !sw.start_stop;

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (inc),
        .clr   (clr_count),
        .value (sec_ones),
        .carry (carry_ones)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (carry_ones),
        .clr   (clr_count),
        .value (sec_tens),
        .carry (carry_tens)
    );

    // Minute pair: a two-digit BCD value wrapping at MAX_MINUTES.
    assign min_at_max = (min_tens == MAX_MIN_TENS) && (min_ones == MAX_MIN_ONES);

    always_comb begin
        min_tens_next = min_tens;
        min_ones_next = min_ones;
        if (clr_count) begin
            min_tens_next = 4'd0;
            min_ones_next = 4'd0;
        end else if (carry_tens) begin
            if (min_at_max) begin
                min_tens_next = 4'd0;
                min_ones_next = 4'd0;
            end else if (min_ones == D_MAX) begin
                min_tens_next = min_tens + 4'd1;
                min_ones_next = 4'd0;
            end else begin
                min_ones_next = min_ones + 4'd1;
            end
        end
    end

    // Seconds as they will be after this edge; the lap capture must include
    // a tick arriving in the same cycle as the lap press.
    assign sec_ones_next = carry_ones ? 4'd0 : (inc ? sec_ones + 4'd1 : sec_ones);
    assign sec_tens_next = carry_tens ? 4'd0 : (carry_ones ? sec_tens + 4'd1 : sec_tens);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_tens     <= 4'd0;
            min_ones     <= 4'd0;
            lap_min_tens <= 4'd0;
            lap_min_ones <= 4'd0;
            lap_sec_tens <= 4'd0;
            lap_sec_ones <= 4'd0;
            wrap         <= 1'b0;
        end else begin
            min_tens <= min_tens_next;
            min_ones <= min_ones_next;
            wrap     <= carry_tens && min_at_max;
            if (lap_capture) begin
                lap_min_tens <= min_tens_next;
                lap_min_ones <= min_ones_next;
                lap_sec_tens <= sec_tens_next;
                lap_sec_ones <= sec_ones_next;
            end
        end
    end

    assign sw.running    = (state == RUN) || (state == LAP);
    assign sw.lap_active = (state == LAP);
    assign sw.wrap       = wrap;
    assign sw.state      = state;
    assign sw.min_tens   = (state == LAP) ? lap_min_tens : min_tens;
    assign sw.min_ones   = (state == LAP) ? lap_min_ones : min_ones;
    assign sw.sec_tens   = (state == LAP) ? lap_sec_tens : sec_tens;
    assign sw.sec_ones   = (state == LAP) ? lap_sec_ones : sec_ones;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Two controllers (MAX_MINUTES 59 and 1) driven by the same event stream and
// checked against a model that keeps the count as plain elapsed seconds.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_LAP   = 3;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    stopwatch_ctrl_if sw0 ();
    stopwatch_ctrl_if sw1 ();

    stopwatch_ctrl #(.MAX_MINUTES(59)) dut0 (.clk(clk), .rst_n(rst_n), .sw(sw0.slave));
    stopwatch_ctrl #(.MAX_MINUTES(1))  dut1 (.clk(clk), .rst_n(rst_n), .sw(sw1.slave));

    // model and scoreboard
    int          max_min [2] = '{59, 1};
    int          m_mode  [2];
    int          m_secs  [2];
    int          m_lap   [2];
    bit          m_wrap  [2];
    logic [18:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [15:0] to_digits(input int s);
        int m, x;
        m = s / 60;
        x = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic logic [15:0] get_disp(input int i);
        if (i == 0) return {sw0.min_tens, sw0.min_ones, sw0.sec_tens, sw0.sec_ones};
        return {sw1.min_tens, sw1.min_ones, sw1.sec_tens, sw1.sec_ones};
    endfunction

    function automatic logic [2:0] get_status(input int i);
        if (i == 0) return {sw0.running, sw0.lap_active, sw0.wrap};
        return {sw1.running, sw1.lap_active, sw1.wrap};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_secs[i] = 0;
            m_lap[i]  = 0;
            m_wrap[i] = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic model_step(input bit t, input bit ss, input bit lr);
        int  period;
        bit  inc;
        logic [15:0] disp;
        for (int i = 0; i < 2; i++) begin
            period    = (max_min[i] + 1) * 60;
            inc       = t && (m_mode[i] == M_RUN || m_mode[i] == M_LAP);
            m_wrap[i] = inc && (m_secs[i] == period - 1);
            if (inc) m_secs[i] = (m_secs[i] + 1) % period;
            case (m_mode[i])
                M_IDLE:  if (ss) m_mode[i] = M_RUN;
                M_RUN:   if (ss) m_mode[i] = M_PAUSE;
                         else if (lr) begin m_mode[i] = M_LAP; m_lap[i] = m_secs[i]; end
                M_LAP:   if (ss) m_mode[i] = M_PAUSE;
                         else if (lr) m_mode[i] = M_RUN;
                default: if (ss) m_mode[i] = M_RUN;
                         else if (lr) begin m_mode[i] = M_IDLE; m_secs[i] = 0; end
            endcase
            disp = to_digits(m_mode[i] == M_LAP ? m_lap[i] : m_secs[i]);
            exp_q.push_back({disp, (m_mode[i] == M_RUN || m_mode[i] == M_LAP),
                             (m_mode[i] == M_LAP), m_wrap[i]});
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // the one per-cycle compare against the model
    task automatic check_dut();
        logic [18:0] e;
        logic [2:0]  st;
        for (int i = 0; i < 2; i++) begin
            e  = exp_q.pop_front();
            st = get_status(i);
            vectors += 4;
            if (get_disp(i) !== e[18:3]) begin
                miscompares++;
                $display("FAIL disp inst%0d t=%0t: got %h expected %h", i, $time, get_disp(i), e[18:3]);
            end
            if (st[2] !== e[2]) begin
                miscompares++;
                $display("FAIL running inst%0d t=%0t: got %b expected %b", i, $time, st[2], e[2]);
            end
            if (st[1] !== e[1]) begin
                miscompares++;
                $display("FAIL lap_active inst%0d t=%0t: got %b expected %b", i, $time, st[1], e[1]);
            end
            if (st[0] !== e[0]) begin
                miscompares++;
                $display("FAIL wrap inst%0d t=%0t: got %b expected %b", i, $time, st[0], e[0]);
            end
        end
    endtask

    // driver tasks
    task automatic cycle(input bit t, input bit ss, input bit lr);
        sw0.tick = t;  sw0.start_stop = ss;  sw0.lap_reset = lr;
        sw1.tick = t;  sw1.start_stop = ss;  sw1.lap_reset = lr;
        @(posedge clk);
        model_step(t, ss, lr);
        @(negedge clk);
        check_dut();
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(1'b1, 1'b0, 1'b0);
    endtask

    // Asserts reset between edges and checks the outputs drop at once.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check_lit($sformatf("reset_disp%0d", i), 32'(get_disp(i)), 32'h0);
            check_lit($sformatf("reset_status%0d", i), 32'(get_status(i)), 32'h0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_lit("reset_state", 32'(sw0.state), 32'(IDLE));
    endtask

    initial begin
        sw0.tick = 1'b0; sw0.start_stop = 1'b0; sw0.lap_reset = 1'b0;
        sw1.tick = 1'b0; sw1.start_stop = 1'b0; sw1.lap_reset = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // ticks ignored in IDLE, then counted in RUN
        ticks(5);
        check_lit("idle_hold", 32'(get_disp(0)), 32'h0000);
        check_lit("idle_running", 32'(sw0.running), 32'h0);
        cycle(1'b0, 1'b1, 1'b0);
        ticks(5);
        check_lit("run_5", 32'(get_disp(0)), 32'h0005);
        check_lit("run_running", 32'(sw0.running), 32'h1);

        // lap freeze and release
        ticks(7);
        cycle(1'b0, 1'b0, 1'b1);
        check_lit("lap_freeze", 32'(get_disp(0)), 32'h0012);
        check_lit("lap_active", 32'(sw0.lap_active), 32'h1);
        ticks(3);
        check_lit("lap_held", 32'(get_disp(0)), 32'h0012);
        cycle(1'b0, 1'b0, 1'b1);
        check_lit("lap_release", 32'(get_disp(0)), 32'h0015);

        // stop with same-cycle tick, then clear from PAUSE
        cycle(1'b1, 1'b1, 1'b0);
        check_lit("stop_tick", 32'(get_disp(0)), 32'h0016);
        check_lit("paused", 32'(sw0.running), 32'h0);
        cycle(1'b0, 1'b0, 1'b1);
        check_lit("clear", 32'(get_disp(0)), 32'h0000);
        check_lit("clear_state", 32'(sw0.state), 32'(IDLE));

        // minute carry and MAX_MINUTES=1 wrap
        cycle(1'b0, 1'b1, 1'b0);
        ticks(60);
        check_lit("min_carry0", 32'(get_disp(0)), 32'h0100);
        check_lit("min_carry1", 32'(get_disp(1)), 32'h0100);
        ticks(60);
        check_lit("no_wrap0", 32'(get_disp(0)), 32'h0200);
        check_lit("wrap_disp1", 32'(get_disp(1)), 32'h0000);
        check_lit("wrap_pulse1", 32'(sw1.wrap), 32'h1);
        ticks(1);
        check_lit("wrap_drop1", 32'(sw1.wrap), 32'h0);
        check_lit("after_wrap1", 32'(get_disp(1)), 32'h0001);

        // both buttons in PAUSE: start_stop wins
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check_lit("both_pause", 32'(get_disp(0)), 32'h0201);
        check_lit("both_running", 32'(sw0.running), 32'h1);
        ticks(478);
        check_lit("at_0959", 32'(get_disp(0)), 32'h0959);
        ticks(1);
        check_lit("to_1000", 32'(get_disp(0)), 32'h1000);

        // async reset in LAP at 03:27
        apply_reset();
        cycle(1'b0, 1'b1, 1'b0);
        ticks(207);
        cycle(1'b0, 1'b0, 1'b1);
        ticks(4);
        check_lit("lap_0327", 32'(get_disp(0)), 32'h0327);
        apply_reset();

        // randomized traffic
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 2499) == 0) begin
                apply_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 39) == 0),
                      1'($urandom_range(0, 29) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
